// File: rtl/seg_display_ctrl_if.sv
// Load handshake between a value producer and the seven-segment controller.
// The master offers a value plus display options; the slave raises ready when it can take it.
interface seg_display_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  mode_dec;
  logic                  blank_lz;

  modport master (output load_valid, load_data, mode_dec, blank_lz, input load_ready);
  modport slave  (input load_valid, load_data, mode_dec, blank_lz, output load_ready);
endinterface

// File: rtl/seg_display_ctrl.sv
// Seven-segment display controller: hex or sequential double-dabble decimal display with
// leading-zero blanking, overflow dashes and a free-running global blink mask.
module seg_display_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int BLINK_DIV      = 25000000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  seg_display_ctrl_if.slave       ld,
  input  logic                    blink_en,
  output logic [NUM_DIGITS*7-1:0] seg,
  output logic                    busy,
  output logic                    overflow
);
  localparam int HW = 4 * NUM_DIGITS;
  localparam int PW = (DATA_WIDTH > HW) ? DATA_WIDTH : HW;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   bin_q, bin_d;
  logic [HW-1:0]           bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    dec_q, dec_d;
  logic                    blz_q, blz_d;
  logic                    cov_q, cov_d;
  logic [NUM_DIGITS*7-1:0] seg_q, seg_d, disp, shown;
  logic                    ovf_q, ovf_d, ovf_now, hex_ovf;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  logic                    phase_q, phase_d;
  logic [PW-1:0]           hex_pad;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // Digit patterns are kept active-high; polarity is applied only at the pins.
  always_comb begin : disp_p
    logic       lead;
    logic [3:0] dig;
    lead    = 1'b1;
    dig     = '0;
    disp    = '0;
    hex_pad = PW'(bin_q);
    hex_ovf = |(hex_pad >> HW);
    ovf_now = dec_q ? cov_q : hex_ovf;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      dig = dec_q ? bcd_q[4*i +: 4] : hex_pad[4*i +: 4];
      if (ovf_now)                                 disp[7*i +: 7] = 7'h40;
      else if (blz_q && lead && dig == 4'd0 && i != 0) disp[7*i +: 7] = 7'h00;
      else                                         disp[7*i +: 7] = glyph(dig);
      if (dig != 4'd0) lead = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    blz_d   = blz_q;
    cov_d   = cov_q;
    seg_d   = seg_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (ld.load_valid) begin
        bin_d   = ld.load_data;
        dec_d   = ld.mode_dec;
        blz_d   = ld.blank_lz;
        cov_d   = 1'b0;
        bcd_d   = '0;
        cnt_d   = CW'(DATA_WIDTH);
        state_d = ld.mode_dec ? CONVERT : UPDATE;
      end
      CONVERT: begin
        // Bit leaving the top BCD digit means the value needs more digits than we have.
        bcd_d = {bcd_adj[HW-2:0], bin_q[DATA_WIDTH-1]};
        bin_d = {bin_q[DATA_WIDTH-2:0], 1'b0};
        cov_d = cov_q | bcd_adj[HW-1];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = UPDATE;
      end
      UPDATE: begin
        seg_d   = disp;
        ovf_d   = ovf_now;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcnt_d  = bcnt_q + 1'b1;
    phase_d = phase_q;
    if (bcnt_q == BW'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      blz_q   <= 1'b0;
      cov_q   <= 1'b0;
      seg_q   <= '0;
      ovf_q   <= 1'b0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      blz_q   <= blz_d;
      cov_q   <= cov_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign shown         = (blink_en && phase_q) ? '0 : seg_q;
  assign seg           = (SEG_ACTIVE_LOW != 0) ? ~shown : shown;
  assign ld.load_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboarded random bench: stimulus pushes model results, a monitor pops them on busy falling.
module tb_seg_display_ctrl;
  localparam int ND = 8;
  localparam int DW = 32;
  localparam int BD = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          blink_en = 1'b0;
  logic [ND*7-1:0] seg;
  logic          busy, overflow;
  int            nchk = 0, nerr = 0;
  int            bk;
  logic [ND*7-1:0] cur_seg = '1;
  logic          cur_ovf = 1'b0;

  typedef struct {
    logic [ND*7-1:0] seg;
    logic            ovf;
    int              lat;
  } exp_t;
  exp_t exp_q[$];

  seg_display_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  seg_display_ctrl #(.NUM_DIGITS(ND), .DATA_WIDTH(DW), .BLINK_DIV(BD), .SEG_ACTIVE_LOW(1)) dut (
    .clock(clock), .resetn(resetn), .ld(bus), .blink_en(blink_en),
    .seg(seg), .busy(busy), .overflow(overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge resetn)
    if (!resetn) bk <= 0;
    else         bk <= bk + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [6:0] font(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] v, input bit dec, input bit blz);
    exp_t            e;
    longint unsigned x;
    int              d[ND];
    int              top;
    logic [6:0]      g;
    x = 64'(v);
    e.ovf = 1'b0;
    if (dec) begin
      e.ovf = (x >= 64'd100000000);
      for (int i = 0; i < ND; i++) begin
        d[i] = int'(x % 64'd10);
        x = x / 64'd10;
      end
      e.lat = DW + 1;
    end else begin
      for (int i = 0; i < ND; i++) d[i] = int'((v >> (4 * i)) & 32'hF);
      e.lat = 1;
    end
    top = 0;
    for (int i = 0; i < ND; i++) if (d[i] != 0) top = i;
    for (int i = 0; i < ND; i++) begin
      if (e.ovf)              g = 7'h40;
      else if (blz && i > top) g = 7'h00;
      else                    g = font(d[i]);
      e.seg[7*i +: 7] = ~g;
    end
    return e;
  endfunction

  // Monitor: busy falling marks a completed display update.
  initial begin
    int   run;
    bit   prev;
    exp_t e;
    run = 0;
    prev = 0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        prev = 0; run = 0; cur_seg = '1; cur_ovf = 1'b0;
        continue;
      end
      chk("ready_vs_busy", 64'(bus.load_ready), 64'(!busy));
      if (busy) begin
        run++;
        if (!blink_en) chk("seg_stable_busy", 64'(seg), 64'(cur_seg));
        chk("ovf_stable_busy", 64'(overflow), 64'(cur_ovf));
      end else if (prev) begin
        if (exp_q.size() == 0) chk("unexpected_update", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("seg", 64'(seg), 64'(e.seg));
          chk("overflow", 64'(overflow), 64'(e.ovf));
          chk("busy_cycles", 64'(run), 64'(e.lat));
          cur_seg = e.seg;
          cur_ovf = e.ovf;
        end
        run = 0;
      end
      prev = busy;
    end
  end

  task automatic load(input logic [31:0] v, input bit dec, input bit blz);
    int w;
    w = 0;
    @(negedge clock);
    while (!bus.load_ready && w < 100) begin @(negedge clock); w++; end
    if (!bus.load_ready) chk("ready_timeout", 64'd0, 64'd1);
    bus.load_valid = 1'b1;
    bus.load_data  = v;
    bus.mode_dec   = dec;
    bus.blank_lz   = blz;
    exp_q.push_back(model(v, dec, blz));
    @(negedge clock);
    bus.load_valid = 1'b0;
    bus.load_data  = $urandom;
    bus.mode_dec   = 1'($urandom);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 200) begin @(negedge clock); w++; end
    if (exp_q.size() != 0 || busy) chk("idle_timeout", 64'd0, 64'd1);
    @(negedge clock);
  endtask

  // Valid held high across a conversion while data and mode churn.
  task automatic back_to_back(input logic [31:0] first);
    int w;
    @(negedge clock);
    while (!bus.load_ready) @(negedge clock);
    bus.load_valid = 1'b1;
    bus.load_data  = first;
    bus.mode_dec   = 1'b1;
    bus.blank_lz   = 1'b0;
    exp_q.push_back(model(first, 1'b1, 1'b0));
    @(negedge clock);
    w = 0;
    while (!bus.load_ready && w < 100) begin
      bus.load_data = $urandom_range(0, 99999999);
      bus.mode_dec  = ~bus.mode_dec;
      bus.blank_lz  = 1'($urandom);
      @(negedge clock);
      w++;
    end
    if (!bus.load_ready) chk("b2b_timeout", 64'd0, 64'd1);
    exp_q.push_back(model(bus.load_data, bus.mode_dec, bus.blank_lz));
    @(negedge clock);
    bus.load_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    bit          dec, blz;
    logic [ND*7-1:0] want;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.mode_dec   = 1'b0;
    bus.blank_lz   = 1'b0;
    #2;
    chk("rst_seg", 64'(seg), 64'(56'hFF_FFFF_FFFF_FFFF));
    chk("rst_ready", 64'(bus.load_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_rst_seg", 64'(seg), 64'(56'hFF_FFFF_FFFF_FFFF));
    chk("post_rst_ready", 64'(bus.load_ready), 64'd1);

    load(32'h0000_00A5, 1'b0, 1'b0); wait_idle();
    load(32'h0000_00A5, 1'b0, 1'b1); wait_idle();
    load(32'd12345678, 1'b1, 1'b0);  wait_idle();
    load(32'd100000000, 1'b1, 1'b1); wait_idle();
    load(32'h1, 1'b0, 1'b0);         wait_idle();
    load(32'd99999999, 1'b1, 1'b0);  wait_idle();
    load(32'hFFFF_FFFF, 1'b1, 1'b0); wait_idle();
    load(32'd0, 1'b1, 1'b1);         wait_idle();
    load(32'h0, 1'b0, 1'b1);         wait_idle();
    load(32'hFFFF_FFFF, 1'b0, 1'b1); wait_idle();

    for (int n = 0; n < 14; n++) begin
      dec = 1'($urandom);
      blz = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99999999);
        2:       v = $urandom_range(0, 255);
        default: v = $urandom & 32'h00F0_0F00;
      endcase
      load(v, dec, blz);
      wait_idle();
    end

    back_to_back(32'd87654321); wait_idle();
    back_to_back(32'd42);       wait_idle();

    load(32'h1234_5678, 1'b0, 1'b0); wait_idle();
    blink_en = 1'b1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clock);
      want = (((bk / BD) % 2) == 1) ? '1 : cur_seg;
      chk("blink", 64'(seg), 64'(want));
    end
    blink_en = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      chk("blink_off", 64'(seg), 64'(cur_seg));
    end

    load(32'd55555, 1'b1, 1'b0);
    repeat (10) @(negedge clock);
    @(posedge clock); #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("midconv_rst_seg", 64'(seg), 64'(56'hFF_FFFF_FFFF_FFFF));
    chk("midconv_rst_ready", 64'(bus.load_ready), 64'd1);
    chk("midconv_rst_busy", 64'(busy), 64'd0);
    chk("midconv_rst_ovf", 64'(overflow), 64'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (40) @(negedge clock);
    chk("no_update_after_rst", 64'(seg), 64'(56'hFF_FFFF_FFFF_FFFF));
    chk("idle_after_rst", 64'(busy), 64'd0);

    load(32'd2024, 1'b1, 1'b1); wait_idle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", nerr, nchk);
    $fatal(1, "watchdog");
  end
endmodule
